// File: rtl/multdiv_seq_ctrl_if.sv
// Handshake bundle between the pipeline (master) and the mult/div iteration sequencer (slave).
interface multdiv_seq_ctrl_if #(
  parameter int unsigned CNT_W = 6
);
  logic             start;
  logic             mode;
  logic             abort;
  logic             early_stop;
  logic             busy;
  logic             load;
  logic             last;
  logic [CNT_W-1:0] count;
  logic             mode_q;
  logic             ready;
  logic             we;
  logic             err;

  modport master (
    output start, mode, abort, early_stop,
    input  busy, load, last, count, mode_q, ready, we, err
  );

  modport slave (
    input  start, mode, abort, early_stop,
    output busy, load, last, count, mode_q, ready, we, err
  );
endinterface

// File: rtl/multdiv_seq_ctrl.sv
// Iteration sequencer for the iterative mult/div unit: runs N datapath cycles per operation
// and returns a one-cycle ready/we pulse, with abort and early-stop handling.
module multdiv_seq_ctrl #(
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 33
) (
  input logic                   clock,
  input logic                   clr_n,
  multdiv_seq_ctrl_if.slave     bus
);

  if (MULT_CYCLES < 1 || DIV_CYCLES < 1 ||
      MULT_CYCLES > (2 ** CNT_W) || DIV_CYCLES > (2 ** CNT_W)) begin : g_bad_params
    $error("multdiv_seq_ctrl: cycle counts must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] MultLast = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLast  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_sel_q, mode_sel_d;
  logic             err_q, err_d;
  logic             is_last;

  // Length comes from the latched mode so mid-run mode changes cannot alter it.
  assign is_last = (count_q == (mode_sel_q ? DivLast : MultLast));

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      mode_sel_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mode_sel_q <= mode_sel_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mode_sel_d = mode_sel_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        count_d = '0;
        err_d   = 1'b0;
        if (bus.start) begin
          state_d    = StRun;
          mode_sel_d = bus.mode;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
          count_d = '0;
        end else if (bus.early_stop) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else if (is_last) begin
          state_d = StDone;
          err_d   = 1'b0;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      StDone: begin
        // Back-to-back start skips the idle bubble.
        count_d = '0;
        err_d   = 1'b0;
        if (bus.start) begin
          state_d    = StRun;
          mode_sel_d = bus.mode;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign bus.busy   = (state_q == StRun);
  assign bus.load   = (state_q == StRun) && (count_q == '0);
  assign bus.last   = (state_q == StRun) && is_last;
  assign bus.count  = count_q;
  assign bus.mode_q = mode_sel_q;
  assign bus.ready  = (state_q == StDone);
  assign bus.we     = (state_q == StDone) && !err_q;
  assign bus.err    = (state_q == StDone) && err_q;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Bench for multdiv_seq_ctrl: directed scenarios plus random traffic against an operation-level model.
module tb_multdiv_seq_ctrl;

  localparam int MULT_N = 32;
  localparam int DIV_N  = 33;

  logic clock = 1'b0;
  logic clr_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  multdiv_seq_ctrl_if #(.CNT_W(6)) ifm ();
  multdiv_seq_ctrl_if #(.CNT_W(2)) ifs ();

  multdiv_seq_ctrl #(.CNT_W(6), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) u_dut (
    .clock (clock),
    .clr_n (clr_n),
    .bus   (ifm)
  );

  multdiv_seq_ctrl #(.CNT_W(2), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut_short (
    .clock (clock),
    .clr_n (clr_n),
    .bus   (ifs)
  );

  // Operation-level model: an op is either in flight (with its age) or just finished.
  bit in_op = 0, fin = 0, fin_err = 0, m_mode = 0;
  int age = 0, len = MULT_N;

  always @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      in_op = 0; fin = 0; fin_err = 0; m_mode = 0; age = 0;
    end else if (fin) begin
      fin = 0; fin_err = 0; age = 0;
      if (ifm.start) begin
        in_op = 1; m_mode = ifm.mode;
      end
    end else if (in_op) begin
      if (ifm.abort) begin
        in_op = 0; age = 0;
      end else if (ifm.early_stop) begin
        in_op = 0; fin = 1; fin_err = 1;
      end else if (age == len - 1) begin
        in_op = 0; fin = 1;
      end else begin
        age++;
      end
    end else if (ifm.start) begin
      in_op = 1; age = 0; m_mode = ifm.mode;
    end
    len = m_mode ? DIV_N : MULT_N;
  end

  function automatic logic [12:0] expected_outs();
    logic [5:0] c;
    c = 6'(age);
    return {in_op, in_op && age == 0, in_op && age == len - 1, c, m_mode,
            fin, fin && !fin_err, fin && fin_err};
  endfunction

  function automatic logic [12:0] dut_outs();
    return {ifm.busy, ifm.load, ifm.last, ifm.count, ifm.mode_q, ifm.ready, ifm.we, ifm.err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) chk("outputs{busy,load,last,count,mode_q,ready,we,err}",
                              32'(dut_outs()), 32'(expected_outs()));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks until ready is seen; returns number of edges waited, toggling mode if asked.
  task automatic wait_ready(input bit toggle_mode, output int k);
    k = 0;
    while (!ifm.ready && k < 200) begin
      if (toggle_mode) ifm.mode = ~ifm.mode;
      tick();
      k++;
    end
    if (!ifm.ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_count(input int c);
    int k = 0;
    while (int'(ifm.count) != c && k < 200) begin
      tick();
      k++;
    end
    if (int'(ifm.count) != c) chk("count_timeout", 32'(ifm.count), 32'(c));
  endtask

  initial begin
    int lat;
    ifm.start = 0; ifm.mode = 0; ifm.abort = 0; ifm.early_stop = 0;
    ifs.start = 0; ifs.mode = 0; ifs.abort = 0; ifs.early_stop = 0;
    repeat (2) tick();
    chk("reset_outs", 32'(dut_outs()), 0);
    chk("reset_short_outs", 32'({ifs.busy, ifs.ready, ifs.count}), 0);
    #3 clr_n = 1;
    tick();

    // Multiply: 32 iterations.
    ifm.start = 1; ifm.mode = 0;
    tick();
    ifm.start = 0;
    chk("mult_load", 32'(ifm.load), 1);
    wait_ready(0, lat);
    chk("mult_latency", 32'(lat), 32);
    chk("mult_we", 32'(ifm.we), 1);
    tick();

    // Divide with mode toggling mid-run.
    ifm.start = 1; ifm.mode = 1;
    tick();
    ifm.start = 0;
    wait_ready(1, lat);
    chk("div_latency", 32'(lat), 33);
    chk("div_mode_q", 32'(ifm.mode_q), 1);
    ifm.mode = 0;
    tick();

    // Back-to-back with start held.
    ifm.start = 1; ifm.mode = 0;
    tick();
    wait_ready(0, lat);
    chk("b2b_first_latency", 32'(lat), 32);
    tick();
    chk("b2b_load", 32'(ifm.load), 1);
    ifm.start = 0;
    wait_ready(0, lat);
    chk("b2b_second_latency", 32'(lat), 32);
    tick();

    // Early stop at count 5 during divide.
    ifm.start = 1; ifm.mode = 1;
    tick();
    ifm.start = 0;
    wait_count(5);
    ifm.early_stop = 1;
    tick();
    ifm.early_stop = 0;
    chk("estop_ready_err_we_count", 32'({ifm.ready, ifm.err, ifm.we, ifm.count}), 32'({3'b110, 6'd5}));
    tick();
    chk("estop_idle", 32'({ifm.busy, ifm.count}), 0);

    // Abort at count 10 with early_stop also high; start held high during run is ignored.
    ifm.start = 1; ifm.mode = 0;
    tick();
    wait_count(10);
    ifm.start = 0; ifm.abort = 1; ifm.early_stop = 1;
    tick();
    ifm.abort = 0; ifm.early_stop = 0;
    chk("abort_idle", 32'({ifm.busy, ifm.ready, ifm.we, ifm.count}), 0);
    tick();

    // Async reset mid-run at count 20.
    ifm.start = 1; ifm.mode = 0;
    tick();
    ifm.start = 0;
    wait_count(20);
    #2 clr_n = 0;
    #1 chk("async_reset_outs", 32'(dut_outs()), 0);
    tick();
    #2 clr_n = 1;
    tick();

    // Single-iteration build: load and last together.
    ifs.start = 1;
    tick();
    ifs.start = 0;
    chk("n1_load_last", 32'({ifs.busy, ifs.load, ifs.last}), 32'(3'b111));
    tick();
    chk("n1_ready_we", 32'({ifs.ready, ifs.we, ifs.busy}), 32'(3'b110));

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!clr_n) clr_n = 1;
      ifm.start      = ($urandom_range(0, 3) == 0);
      ifm.mode       = 1'($urandom);
      ifm.abort      = ($urandom_range(0, 40) == 0);
      ifm.early_stop = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 599) == 0) #2 clr_n = 0;
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
